// File: rtl/cache_mem_arbiter.sv
// I/D-cache refill read arbiter and D-cache writeback serialiser on one memory port.
// Optional: define ARB_RR_EN for round-robin read arbitration (default: D-cache priority).
module cache_mem_arbiter #(
  parameter int LINE_BEATS = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ic_rd_req,
  input  logic [31:0]  ic_rd_addr,
  output logic         ic_rd_rdy,
  output logic         ic_ret_valid,
  output logic         ic_ret_last,
  output logic [31:0]  ic_ret_data,
  input  logic         dc_rd_req,
  input  logic [31:0]  dc_rd_addr,
  output logic         dc_rd_rdy,
  output logic         dc_ret_valid,
  output logic         dc_ret_last,
  output logic [31:0]  dc_ret_data,
  input  logic         dc_wr_req,
  input  logic [31:0]  dc_wr_addr,
  input  logic [127:0] dc_wr_data,
  output logic         dc_wr_rdy,
  output logic         mem_rd_req,
  output logic [31:0]  mem_rd_addr,
  input  logic         mem_rd_rdy,
  input  logic         mem_ret_valid,
  input  logic         mem_ret_last,
  input  logic [31:0]  mem_ret_data,
  output logic         mem_wr_req,
  output logic [31:0]  mem_wr_addr,
  input  logic         mem_wr_rdy,
  output logic         mem_wr_valid,
  output logic [31:0]  mem_wr_data,
  output logic         mem_wr_last,
  input  logic         mem_wr_beat_rdy,
  input  logic         mem_wr_done
);

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_t;

  r_state_t       r_state;
  w_state_t       w_state;
  logic           owner_dc;
  logic [31:0]    rd_addr_q;
  logic [127:0]   wb_data;
  logic [27:0]    wb_line;
  logic           wb_valid;
  logic [1:0]     beat_cnt;

  logic wr_acc, ic_haz, dc_haz, elig_ic, elig_dc;
  logic gnt_ic, gnt_dc, in_data;
  logic unused_addr_lsb;

  assign unused_addr_lsb = ^{ic_rd_addr[3:0], dc_rd_addr[3:0], dc_wr_addr[3:0]};

  assign dc_wr_rdy = rst_n && (w_state == W_IDLE);
  assign wr_acc    = dc_wr_req && dc_wr_rdy;

  // A same-cycle writeback accept also blocks a read of that line
  assign ic_haz = (wb_valid && ic_rd_addr[31:4] == wb_line) ||
                  (wr_acc && ic_rd_addr[31:4] == dc_wr_addr[31:4]);
  assign dc_haz = (wb_valid && dc_rd_addr[31:4] == wb_line) ||
                  (wr_acc && dc_rd_addr[31:4] == dc_wr_addr[31:4]);

  assign elig_ic = rst_n && (r_state == R_IDLE) && ic_rd_req && !ic_haz;
  assign elig_dc = rst_n && (r_state == R_IDLE) && dc_rd_req && !dc_haz;

`ifdef ARB_RR_EN
  logic last_grant;

  assign gnt_dc = elig_dc && (!elig_ic || !last_grant);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      last_grant <= 1'b0;
    else if (gnt_ic || gnt_dc)
      last_grant <= gnt_dc;
  end
`else
  assign gnt_dc = elig_dc;
`endif

  assign gnt_ic    = elig_ic && !gnt_dc;
  assign ic_rd_rdy = gnt_ic;
  assign dc_rd_rdy = gnt_dc;

  assign mem_rd_req  = (r_state == R_ADDR);
  assign mem_rd_addr = rd_addr_q;

  assign in_data      = (r_state == R_DATA);
  assign ic_ret_valid = in_data && !owner_dc && mem_ret_valid;
  assign dc_ret_valid = in_data && owner_dc && mem_ret_valid;
  assign ic_ret_last  = ic_ret_valid && mem_ret_last;
  assign dc_ret_last  = dc_ret_valid && mem_ret_last;
  assign ic_ret_data  = in_data ? mem_ret_data : '0;
  assign dc_ret_data  = in_data ? mem_ret_data : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= R_IDLE;
      owner_dc  <= 1'b0;
      rd_addr_q <= '0;
    end else begin
      unique case (r_state)
        R_IDLE: if (gnt_ic || gnt_dc) begin
          owner_dc  <= gnt_dc;
          rd_addr_q <= gnt_dc ? {dc_rd_addr[31:4], 4'b0}
                              : {ic_rd_addr[31:4], 4'b0};
          r_state   <= R_ADDR;
        end
        R_ADDR: if (mem_rd_rdy) r_state <= R_DATA;
        R_DATA: if (mem_ret_valid && mem_ret_last) r_state <= R_IDLE;
        default: r_state <= R_IDLE;
      endcase
    end
  end

  assign mem_wr_req   = (w_state == W_ADDR);
  assign mem_wr_addr  = {wb_line, 4'b0};
  assign mem_wr_valid = (w_state == W_DATA);
  assign mem_wr_data  = mem_wr_valid ? wb_data[{beat_cnt, 5'd0} +: 32] : '0;
  assign mem_wr_last  = mem_wr_valid && (beat_cnt == 2'(LINE_BEATS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state  <= W_IDLE;
      wb_data  <= '0;
      wb_line  <= '0;
      wb_valid <= 1'b0;
      beat_cnt <= '0;
    end else begin
      unique case (w_state)
        W_IDLE: if (wr_acc) begin
          wb_data  <= dc_wr_data;
          wb_line  <= dc_wr_addr[31:4];
          wb_valid <= 1'b1;
          beat_cnt <= '0;
          w_state  <= W_ADDR;
        end
        W_ADDR: if (mem_wr_rdy) w_state <= W_DATA;
        W_DATA: if (mem_wr_beat_rdy) begin
          beat_cnt <= beat_cnt + 2'd1;
          if (mem_wr_last) w_state <= W_RESP;
        end
        W_RESP: if (mem_wr_done) begin
          wb_valid <= 1'b0;
          w_state  <= W_IDLE;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

endmodule
